alu_control_decoder: RTL and testbench
======================================

ALU_CONTROL_DECODER -- requirements
Module: alu_control_decoder

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the illegal-instruction counter.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have Inst_i  input  32  RISC-V instruction word from fetch.
REQ-005 SHALL have Inst_Valid_i  input  1  Inst_i valid.
REQ-006 SHALL have Inst_Ready_o  output  1  decoder can accept Inst_i this cycle.
REQ-007 SHALL have Dec_Valid_o  output  1  decoded bundle valid.
REQ-008 SHALL have Dec_Ready_i  input  1  downstream (register read/ALU) accepts bundle.
REQ-009 SHALL have ALU_Operation_o  output  4  ALU opcode: ADD 0000, SUB 0001, OR 0010, LUI 0100, SLL 0101, SRL 0110.
REQ-010 SHALL have Imm_o  output  32  B-operand immediate.
REQ-011 SHALL have ALU_Src_o  output  1  1 = B from Imm_o, 0 = B from rs2.
REQ-012 SHALL have Reg_Write_o  output  1  write rd.
REQ-013 SHALL have Rs1_o, Rs2_o, Rd_o  output  5 each  Inst_i[19:15], [24:20], [11:7].
REQ-014 SHALL have Illegal_o  output  1  instruction not in the supported set.
REQ-015 SHALL have Clear_Count_i  input  1  synchronous clear of counter.
REQ-016 SHALL have Illegal_Count_o  output  CNT_WIDTH  accepted illegal instructions, saturating.

Function
REQ-017 SHALL decode OP-IMM (0010011): f3 000 addi->ADD; 110 ori->OR; Imm_o = sign-extended Inst_i[31:20]; ALU_Src_o=1.
REQ-018 SHALL decode slli (f3 001) ->SLL and srli (f3 101) ->SRL only when Inst_i[31:25]=0000000; Imm_o = zero-extended Inst_i[24:20]; other f7 illegal.
REQ-019 SHALL decode OP (0110011) with ALU_Src_o=0, Imm_o=0: f7 0000000 with f3 000/110/001/101 -> ADD/OR/SLL/SRL; f7 0100000 f3 000 -> SUB; other combinations illegal.
REQ-020 SHALL decode LUI (0110111) ->LUI, Imm_o = {12'b0, Inst_i[31:12]}, ALU_Src_o=1.
REQ-021 SHALL, for any other opcode or illegal combination, output Illegal_o=1, ALU_Operation_o=0000, Reg_Write_o=0, Imm_o=0, ALU_Src_o=0; Reg_Write_o=1 for every legal instruction.
REQ-022 SHALL transfer input when Inst_Valid_i && Inst_Ready_o, output when Dec_Valid_o && Dec_Ready_i.
REQ-023 SHALL decode combinationally and register into a 2-entry skid buffer: output register (OUT) plus skid register (SKID).
REQ-024 SHALL give 1-cycle latency: bundle accepted in cycle N with OUT empty or draining appears on outputs in cycle N+1.
REQ-025 SHALL drive Inst_Ready_o = !SKID_full && !reset; no combinational path from Dec_Ready_i to Inst_Ready_o.
REQ-026 SHALL load SKID when input accepted while OUT full and not draining; SHALL move SKID to OUT when OUT drains and SKID full, same cycle any new input is taken into SKID.
REQ-027 SHALL hold all output fields stable while Dec_Valid_o=1 and Dec_Ready_i=0.
REQ-028 SHALL preserve order; no bundle dropped or duplicated.
REQ-029 SHALL increment Illegal_Count_o by 1 on acceptance of an illegal instruction, saturate at 2^CNT_WIDTH-1.
REQ-030 SHALL, with Clear_Count_i and illegal acceptance in the same cycle, set count to 0 (clear wins).

Reset
REQ-031 SHALL, with reset high at a clock edge, clear OUT, SKID and counter: Dec_Valid_o=0, all data outputs 0, Illegal_Count_o=0; inputs ignored.
REQ-032 SHALL hold Inst_Ready_o=0 while reset is high and 1 in the first cycle after release; reset mid-operation discards all buffered bundles.

Verification
REQ-033 SHALL check: Inst_i=0xFFF00293 (addi x5,x0,-1), Dec_Ready_i=1 -> next cycle Dec_Valid_o=1, op 0000, Imm_o=0xFFFFFFFF, ALU_Src_o=1, Rd_o=5, Reg_Write_o=1.
REQ-034 SHALL check: 0x123450B7 (lui x1,0x12345) -> op 0100, Imm_o=0x00012345; 0x402081B3 (sub x3,x1,x2) -> op 0001, ALU_Src_o=0, Rs1_o=1, Rs2_o=2, Rd_o=3.
REQ-035 SHALL check: Dec_Ready_i=0, three back-to-back valid instructions -> first two accepted, Inst_Ready_o=0 after second; Dec_Ready_i=1 -> all three emitted in order, none lost/duplicated.
REQ-036 SHALL check: 0x00000000 -> Illegal_o=1, op 0000, Reg_Write_o=0, count 1; CNT_WIDTH=2, five illegals -> count 3; Clear_Count_i with illegal accept -> count 0.
REQ-037 SHALL check: 0x4010D093 (srai) -> Illegal_o=1; 0x0010D093 (srli x1,x1,1) -> op 0110, Imm_o=1.
REQ-038 SHALL check: both entries full, reset pulsed one cycle -> Dec_Valid_o=0, Inst_Ready_o=0 during reset, 1 next cycle, no stale bundle emitted.

Source files
------------

// File: rtl/alu_control_decoder_if.sv
// Bundle of decoder-side signals: fetch handshake, decoded bundle handshake and
// illegal-instruction counter controls.
interface alu_control_decoder_if #(
    parameter int CNT_WIDTH = 16
);
    logic [31:0]          Inst_i;
    logic                 Inst_Valid_i;
    logic                 Inst_Ready_o;
    logic                 Dec_Valid_o;
    logic                 Dec_Ready_i;
    logic [3:0]           ALU_Operation_o;
    logic [31:0]          Imm_o;
    logic                 ALU_Src_o;
    logic                 Reg_Write_o;
    logic [4:0]           Rs1_o;
    logic [4:0]           Rs2_o;
    logic [4:0]           Rd_o;
    logic                 Illegal_o;
    logic                 Clear_Count_i;
    logic [CNT_WIDTH-1:0] Illegal_Count_o;

    modport master (
        output Inst_i, Inst_Valid_i, Dec_Ready_i, Clear_Count_i,
        input  Inst_Ready_o, Dec_Valid_o, ALU_Operation_o, Imm_o, ALU_Src_o,
               Reg_Write_o, Rs1_o, Rs2_o, Rd_o, Illegal_o, Illegal_Count_o
    );

    modport slave (
        input  Inst_i, Inst_Valid_i, Dec_Ready_i, Clear_Count_i,
        output Inst_Ready_o, Dec_Valid_o, ALU_Operation_o, Imm_o, ALU_Src_o,
               Reg_Write_o, Rs1_o, Rs2_o, Rd_o, Illegal_o, Illegal_Count_o
    );
endinterface

// File: rtl/alu_control_decoder.sv
// RV32 subset ALU-control decoder: combinational decode feeding a 2-entry skid
// buffer (OUT + SKID), with a saturating counter of accepted illegal instructions.
module alu_control_decoder #(
    parameter int CNT_WIDTH = 16
) (
    input logic                 clk,
    input logic                 reset,
    alu_control_decoder_if.slave bus
);
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] imm;
        logic        alu_src;
        logic        reg_write;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } bundle_t;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    bundle_t     dec;

    assign inst   = bus.Inst_i;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    // Fields left at zero on any unsupported encoding give the illegal bundle.
    always_comb begin
        dec         = '0;
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.rd      = inst[11:7];
        dec.illegal = 1'b1;
        case (opcode)
            OPC_OP_IMM: begin
                case (funct3)
                    3'b000, 3'b110: begin
                        dec.op      = (funct3 == 3'b000) ? ALU_ADD : ALU_OR;
                        dec.imm     = {{20{inst[31]}}, inst[31:20]};
                        dec.alu_src = 1'b1;
                        dec.illegal = 1'b0;
                    end
                    3'b001, 3'b101: begin
                        if (funct7 == 7'b0000000) begin
                            dec.op      = (funct3 == 3'b001) ? ALU_SLL : ALU_SRL;
                            dec.imm     = {27'd0, inst[24:20]};
                            dec.alu_src = 1'b1;
                            dec.illegal = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: begin dec.op = ALU_ADD; dec.illegal = 1'b0; end
                        3'b110: begin dec.op = ALU_OR;  dec.illegal = 1'b0; end
                        3'b001: begin dec.op = ALU_SLL; dec.illegal = 1'b0; end
                        3'b101: begin dec.op = ALU_SRL; dec.illegal = 1'b0; end
                        default: ;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.op      = ALU_SUB;
                    dec.illegal = 1'b0;
                end
            end
            OPC_LUI: begin
                dec.op      = ALU_LUI;
                dec.imm     = {12'd0, inst[31:12]};
                dec.alu_src = 1'b1;
                dec.illegal = 1'b0;
            end
            default: ;
        endcase
        dec.reg_write = !dec.illegal;
    end

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and ready depends only on registered state.
    bundle_t              out_q;
    bundle_t              skid_q;
    logic                 out_full;
    logic                 skid_full;
    logic [CNT_WIDTH-1:0] count;
    logic                 in_fire;
    logic                 out_fire;

    assign bus.Inst_Ready_o = !skid_full && !reset;
    assign in_fire          = bus.Inst_Valid_i && bus.Inst_Ready_o;
    assign out_fire         = out_full && bus.Dec_Ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= '0;
            skid_q    <= '0;
            out_full  <= 1'b0;
            skid_full <= 1'b0;
        end else if (out_fire || !out_full) begin
            // OUT is free this edge: refill from SKID first to keep order.
            if (skid_full) begin
                out_q    <= skid_q;
                out_full <= 1'b1;
                if (in_fire) begin
                    skid_q <= dec;
                end else begin
                    skid_full <= 1'b0;
                end
            end else if (in_fire) begin
                out_q    <= dec;
                out_full <= 1'b1;
            end else begin
                out_full <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q    <= dec;
            skid_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.Clear_Count_i) begin
            count <= '0;
        end else if (in_fire && dec.illegal && count != {CNT_WIDTH{1'b1}}) begin
            count <= count + 1'b1;
        end
    end

    assign bus.Dec_Valid_o     = out_full;
    assign bus.ALU_Operation_o = out_q.op;
    assign bus.Imm_o           = out_q.imm;
    assign bus.ALU_Src_o       = out_q.alu_src;
    assign bus.Reg_Write_o     = out_q.reg_write;
    assign bus.Rs1_o           = out_q.rs1;
    assign bus.Rs2_o           = out_q.rs2;
    assign bus.Rd_o            = out_q.rd;
    assign bus.Illegal_o       = out_q.illegal;
    assign bus.Illegal_Count_o = count;
endmodule

// File: tb/tb_alu_control_decoder.sv
// Bench for alu_control_decoder: directed vectors, skid/backpressure, counter
// saturation (second instance with a 2-bit counter), random traffic and reset.
module tb_alu_control_decoder;
    logic clk = 1'b0;
    logic reset;
    logic rand_mode;
    always #5 clk = ~clk;

    alu_control_decoder_if #(.CNT_WIDTH(16)) ifc ();
    alu_control_decoder_if #(.CNT_WIDTH(2))  ifs ();

    alu_control_decoder #(.CNT_WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(ifc.slave));
    alu_control_decoder #(.CNT_WIDTH(2))  dut_sat (.clk(clk), .reset(reset), .bus(ifs.slave));

    assign ifs.Inst_i        = ifc.Inst_i;
    assign ifs.Inst_Valid_i  = ifc.Inst_Valid_i;
    assign ifs.Dec_Ready_i   = ifc.Dec_Ready_i;
    assign ifs.Clear_Count_i = ifc.Clear_Count_i;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [53:0] exp_q[$];
    logic [53:0] got_b;
    logic [53:0] mon_b;
    logic [15:0] cnt_m;
    logic [1:0]  cnt_s_m;

    assign got_b = {ifc.ALU_Operation_o, ifc.Imm_o, ifc.ALU_Src_o, ifc.Reg_Write_o,
                    ifc.Rs1_o, ifc.Rs2_o, ifc.Rd_o, ifc.Illegal_o};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [53:0] ref_decode(input logic [31:0] w);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [3:0]  op;
        logic [31:0] imm;
        logic        src;
        logic        ok;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        op  = 4'd0;
        imm = 32'd0;
        src = 1'b0;
        ok  = 1'b0;
        if (opc == 7'h13) begin
            if (f3 == 3'd0 || f3 == 3'd6) begin
                ok = 1'b1; src = 1'b1;
                imm = {{20{w[31]}}, w[31:20]};
                op = (f3 == 3'd0) ? 4'd0 : 4'd2;
            end else if ((f3 == 3'd1 || f3 == 3'd5) && f7 == 7'd0) begin
                ok = 1'b1; src = 1'b1;
                imm = {27'd0, w[24:20]};
                op = (f3 == 3'd1) ? 4'd5 : 4'd6;
            end
        end else if (opc == 7'h33) begin
            if (f7 == 7'd0 && (f3 == 3'd0 || f3 == 3'd6 || f3 == 3'd1 || f3 == 3'd5)) begin
                ok = 1'b1;
                op = (f3 == 3'd0) ? 4'd0 : (f3 == 3'd6) ? 4'd2 : (f3 == 3'd1) ? 4'd5 : 4'd6;
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                ok = 1'b1;
                op = 4'd1;
            end
        end else if (opc == 7'h37) begin
            ok = 1'b1; src = 1'b1; op = 4'd4;
            imm = {12'd0, w[31:12]};
        end
        return {op, imm, src, ok, w[19:15], w[24:20], w[11:7], !ok};
    endfunction

    // Scoreboard monitor: compares the head of exp_q while a bundle is presented.
    always @(negedge clk) begin
        if (reset) begin
            check("rdy_in_reset", ifc.Inst_Ready_o, 1'b0);
            exp_q.delete();
            cnt_m   = 16'd0;
            cnt_s_m = 2'd0;
        end else begin
            check("cnt16", ifc.Illegal_Count_o, cnt_m);
            check("cnt2", ifs.Illegal_Count_o, cnt_s_m);
            if (ifc.Dec_Valid_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", ifc.Dec_Valid_o, 1'b0);
                end else begin
                    check(ifc.Dec_Ready_i ? "pop" : "hold", got_b, exp_q[0]);
                    if (ifc.Dec_Ready_i) void'(exp_q.pop_front());
                end
            end
            mon_b = ref_decode(ifc.Inst_i);
            if (ifc.Inst_Valid_i && ifc.Inst_Ready_o) exp_q.push_back(mon_b);
            if (ifc.Clear_Count_i) begin
                cnt_m   = 16'd0;
                cnt_s_m = 2'd0;
            end else if (ifc.Inst_Valid_i && ifc.Inst_Ready_o && mon_b[0]) begin
                if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
                if (cnt_s_m != 2'd3) cnt_s_m = cnt_s_m + 2'd1;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            ifc.Dec_Ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic wait_accept();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (ifc.Inst_Ready_o) done = 1'b1;
        end
        check("accept_timeout", done, 1'b1);
        @(posedge clk);
        #1;
        ifc.Inst_Valid_i = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        @(posedge clk);
        #1;
        ifc.Inst_i       = w;
        ifc.Inst_Valid_i = 1'b1;
        wait_accept();
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !ifc.Dec_Valid_o) break;
        end
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] op, input logic [31:0] imm,
                              input logic src, input logic rw, input logic ill);
        check({tag, "_valid"}, ifc.Dec_Valid_o, 1'b1);
        check({tag, "_op"}, ifc.ALU_Operation_o, op);
        check({tag, "_imm"}, ifc.Imm_o, imm);
        check({tag, "_src"}, ifc.ALU_Src_o, src);
        check({tag, "_rw"}, ifc.Reg_Write_o, rw);
        check({tag, "_ill"}, ifc.Illegal_o, ill);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w[6:0] = 7'h13;
            1: w[6:0] = 7'h33;
            2: w[6:0] = 7'h37;
            default: ;
        endcase
        case ($urandom_range(0, 2))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        rand_mode         = 1'b0;
        ifc.Inst_i        = 32'd0;
        ifc.Inst_Valid_i  = 1'b0;
        ifc.Dec_Ready_i   = 1'b1;
        ifc.Clear_Count_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", ifc.Inst_Ready_o, 1'b1);
        check("rst_valid", ifc.Dec_Valid_o, 1'b0);
        check("rst_imm", ifc.Imm_o, 32'd0);
        check("rst_cnt", ifc.Illegal_Count_o, 16'd0);

        send(32'hFFF00293);
        @(negedge clk);
        expect_out("addi", 4'b0000, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
        check("addi_rd", ifc.Rd_o, 5'd5);

        send(32'h123450B7);
        @(negedge clk);
        expect_out("lui", 4'b0100, 32'h00012345, 1'b1, 1'b1, 1'b0);
        check("lui_rd", ifc.Rd_o, 5'd1);

        send(32'h402081B3);
        @(negedge clk);
        expect_out("sub", 4'b0001, 32'd0, 1'b0, 1'b1, 1'b0);
        check("sub_rs1", ifc.Rs1_o, 5'd1);
        check("sub_rs2", ifc.Rs2_o, 5'd2);
        check("sub_rd", ifc.Rd_o, 5'd3);

        // Three back-to-back instructions against a stalled consumer.
        @(posedge clk);
        #1;
        ifc.Dec_Ready_i  = 1'b0;
        ifc.Inst_i       = 32'h00A00313;
        ifc.Inst_Valid_i = 1'b1;
        @(negedge clk);
        check("b2b_rdy1", ifc.Inst_Ready_o, 1'b1);
        @(posedge clk);
        #1 ifc.Inst_i = 32'h0020E3B3;
        @(negedge clk);
        check("b2b_rdy2", ifc.Inst_Ready_o, 1'b1);
        @(posedge clk);
        #1 ifc.Inst_i = 32'h00309413;
        @(negedge clk);
        check("b2b_rdy_full", ifc.Inst_Ready_o, 1'b0);
        check("b2b_head_imm", ifc.Imm_o, 32'd10);
        repeat (2) begin
            @(negedge clk);
            check("b2b_rdy_stall", ifc.Inst_Ready_o, 1'b0);
        end
        @(posedge clk);
        #1 ifc.Dec_Ready_i = 1'b1;
        wait_accept();
        drain();

        send(32'h00000000);
        @(negedge clk);
        expect_out("zero", 4'b0000, 32'd0, 1'b0, 1'b0, 1'b1);
        check("zero_cnt", ifc.Illegal_Count_o, 16'd1);

        send(32'h4010D093);
        @(negedge clk);
        check("srai_ill", ifc.Illegal_o, 1'b1);

        send(32'h0010D093);
        @(negedge clk);
        expect_out("srli", 4'b0110, 32'd1, 1'b1, 1'b1, 1'b0);

        repeat (4) send(32'hFFFFFFFF);
        @(negedge clk);
        check("sat_cnt2", ifs.Illegal_Count_o, 2'd3);
        check("sat_cnt16", ifc.Illegal_Count_o, 16'd6);

        @(posedge clk);
        #1;
        ifc.Clear_Count_i = 1'b1;
        ifc.Inst_i        = 32'h00000000;
        ifc.Inst_Valid_i  = 1'b1;
        wait_accept();
        ifc.Clear_Count_i = 1'b0;
        @(negedge clk);
        check("clr_cnt16", ifc.Illegal_Count_o, 16'd0);
        check("clr_cnt2", ifs.Illegal_Count_o, 2'd0);

        rand_mode = 1'b1;
        repeat (60) send(rand_inst());
        rand_mode = 1'b0;
        @(posedge clk);
        #1 ifc.Dec_Ready_i = 1'b1;
        drain();

        // Fill OUT and SKID, then reset: nothing buffered may come out afterwards.
        @(posedge clk);
        #1 ifc.Dec_Ready_i = 1'b0;
        send(32'h00100493);
        send(32'h00200513);
        @(negedge clk);
        check("full_rdy", ifc.Inst_Ready_o, 1'b0);
        check("full_valid", ifc.Dec_Valid_o, 1'b1);
        @(posedge clk);
        #1;
        reset            = 1'b1;
        ifc.Inst_i       = 32'h00000000;
        ifc.Inst_Valid_i = 1'b1;
        @(negedge clk);
        check("mid_rst_rdy", ifc.Inst_Ready_o, 1'b0);
        @(posedge clk);
        #1;
        reset            = 1'b0;
        ifc.Inst_Valid_i = 1'b0;
        ifc.Dec_Ready_i  = 1'b1;
        @(negedge clk);
        check("post_rst_valid", ifc.Dec_Valid_o, 1'b0);
        check("post_rst_rdy", ifc.Inst_Ready_o, 1'b1);
        check("post_rst_op", ifc.ALU_Operation_o, 4'd0);
        check("post_rst_rd", ifc.Rd_o, 5'd0);
        check("post_rst_cnt", ifc.Illegal_Count_o, 16'd0);
        repeat (3) begin
            @(negedge clk);
            check("no_stale", ifc.Dec_Valid_o, 1'b0);
        end
        send(32'h123450B7);
        drain();

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
